// File: rtl/rom_seq_player_if.sv
// Bus between the game control unit and the pattern ROM / sequence player.
// Latency: n/a (wires only); the player registers every output.
// Backpressure: none; requests are single-cycle pulses, next paces playback.
// Ports: master = control unit (drives rd_en/address/start/next/limit),
//        slave  = player (drives data_out/data_valid/seq_addr/busy/done,
//        plus parity when ROM_SEQ_PARITY_EN is defined).
interface rom_seq_player_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] address;
  logic              start;
  logic              next;
  logic [ADDR_W-1:0] limit;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] seq_addr;
  logic              busy;
  logic              done;
`ifdef ROM_SEQ_PARITY_EN
  logic              parity;
`endif

  modport master (
    output rd_en, address, start, next, limit,
`ifdef ROM_SEQ_PARITY_EN
    input  parity,
`endif
    input  data_out, data_valid, seq_addr, busy, done
  );

  modport slave (
    input  rd_en, address, start, next, limit,
`ifdef ROM_SEQ_PARITY_EN
    output parity,
`endif
    output data_out, data_valid, seq_addr, busy, done
  );
endinterface

// File: rtl/rom_seq_player.sv
// One-hot pattern ROM (ROM[a] = 1 << (a mod DATA_W)) with random reads and sequenced playback.
// Latency: 1 cycle from request (rd_en/start/next) to data_out/data_valid.
// Backpressure: none; the control unit paces playback with next, one element per cycle max.
// Ports: clock, reset (synchronous, active-low), bus (rom_seq_player_if.slave).
// Optional: define ROM_SEQ_PARITY_EN to add bus.parity = registered XOR of data_out.
module rom_seq_player #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  rom_seq_player_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic              done_q, done_d;

  // Table contents are a pure function of the address, so no storage array.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    rom_word = DATA_W'(1) << (int'(a) % DATA_W);
  endfunction

  always_comb begin
    state_nxt = state;
    data_d    = data_q;
    vld_d     = 1'b0;
    addr_d    = addr_q;
    lim_d     = lim_q;
    done_d    = 1'b0;
    if (bus.start) begin
      // start wins in either state, including over a simultaneous next
      state_nxt = PLAY;
      lim_d     = bus.limit;
      addr_d    = '0;
      data_d    = rom_word('0);
      vld_d     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rd_en) begin
            data_d = rom_word(bus.address);
            vld_d  = 1'b1;
          end
        end
        PLAY: begin
          if (bus.next) begin
            if (addr_q < lim_q) begin
              addr_d = addr_q + ADDR_W'(1);
              data_d = rom_word(addr_q + ADDR_W'(1));
              vld_d  = 1'b1;
            end else begin
              // last element consumed: data and address hold
              done_d    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      data_q <= '0;
      vld_q  <= 1'b0;
      addr_q <= '0;
      lim_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      data_q <= data_d;
      vld_q  <= vld_d;
      addr_q <= addr_d;
      lim_q  <= lim_d;
      done_q <= done_d;
    end
  end

`ifdef ROM_SEQ_PARITY_EN
  logic par_q;

  // Tracks data_d so it changes on exactly the same edge as data_out.
  always_ff @(posedge clock) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= ^data_d;
  end

  assign bus.parity = par_q;
`endif

  assign bus.data_out   = data_q;
  assign bus.data_valid = vld_q;
  assign bus.seq_addr   = addr_q;
  assign bus.busy       = (state == PLAY);
  assign bus.done       = done_q;

endmodule
